// File: rtl/axi_ram_init_pkg.sv
// Shared state encoding and AXI field encodings for the RAM init controller.
package axi_ram_init_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WR_AW,
      ST_WR_W,
      ST_WR_B,
      ST_RD_AR,
      ST_RD_R,
      ST_DONE
   } state_t;

   localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;
   localparam logic [1:0] AXI_BURST_INCR = 2'b01;
   localparam logic [2:0] AXI_SIZE_8B    = 3'd3;
   localparam int         BEAT_BYTES     = 8;

endpackage

// File: rtl/axi_ram_init_pattern.sv
// Address-tagged fill word: combinational, zero latency, no flow control.
module axi_ram_init_pattern #(
   parameter logic [63:0] FILL_PATTERN = 64'h0
) (
   input  logic [31:0] addr,
   output logic [63:0] data
);

   assign data = FILL_PATTERN ^ {32'h0, addr};

endmodule

// File: rtl/axi_ram_init_ctrl.sv
// Fills RAM with an address-tagged pattern in INCR bursts, one burst in flight; stalls on AXI ready/valid.
// Readback check is built only with RAM_INIT_VERIFY_EN; flags rise one cycle after the final/failing handshake.
module axi_ram_init_ctrl
   import axi_ram_init_pkg::*;
#(
   parameter int unsigned MEM_SIZE     = 32'h10000,
   parameter logic [31:0] BASE_ADDR    = 32'h0,
   parameter int          BURST_LEN    = 16,
   parameter int          ID_WIDTH     = 6,
   parameter logic [63:0] FILL_PATTERN = 64'h0
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                i_start,
   output logic                o_init_done,
   output logic                o_init_error,
   output logic [ID_WIDTH-1:0] o_awid,
   output logic [31:0]         o_awaddr,
   output logic [7:0]          o_awlen,
   output logic [2:0]          o_awsize,
   output logic [1:0]          o_awburst,
   output logic                o_awvalid,
   input  logic                i_awready,
   output logic [63:0]         o_wdata,
   output logic [7:0]          o_wstrb,
   output logic                o_wlast,
   output logic                o_wvalid,
   input  logic                i_wready,
   input  logic [ID_WIDTH-1:0] i_bid,
   input  logic [1:0]          i_bresp,
   input  logic                i_bvalid,
   output logic                o_bready,
   output logic [ID_WIDTH-1:0] o_arid,
   output logic [31:0]         o_araddr,
   output logic [7:0]          o_arlen,
   output logic [2:0]          o_arsize,
   output logic [1:0]          o_arburst,
   output logic                o_arvalid,
   input  logic                i_arready,
   input  logic [ID_WIDTH-1:0] i_rid,
   input  logic [63:0]         i_rdata,
   input  logic [1:0]          i_rresp,
   input  logic                i_rlast,
   input  logic                i_rvalid,
   output logic                o_rready
);

   localparam int unsigned        BURST_BYTES = BURST_LEN * BEAT_BYTES;
   localparam int unsigned        NUM_BURSTS  = MEM_SIZE / BURST_BYTES;
   localparam int                 BURST_W     = $clog2(NUM_BURSTS) + 1;
   localparam int                 BEAT_W      = $clog2(BURST_LEN) + 1;
   localparam logic [BURST_W-1:0] LAST_BURST  = BURST_W'(NUM_BURSTS - 1);
   localparam logic [BEAT_W-1:0]  LAST_BEAT   = BEAT_W'(BURST_LEN - 1);
   localparam logic [7:0]         AXI_LEN     = 8'(BURST_LEN - 1);

   state_t               state, nxt_state;
   logic [31:0]          burst_addr, nxt_burst_addr;
   logic [31:0]          beat_addr, nxt_beat_addr;
   logic [BURST_W-1:0]   burst_cnt, nxt_burst_cnt;
   logic [BEAT_W-1:0]    beat_cnt, nxt_beat_cnt;
   logic                 done_q, nxt_done;
   logic                 error_q, nxt_error;
   logic [63:0]          pat_data;
   logic                 last_beat;
   logic                 last_burst;
   logic                 aw_phase;
   logic                 w_phase;

   // One generator serves both phases: only one of them walks beat_addr at a time.
   axi_ram_init_pattern #(
      .FILL_PATTERN(FILL_PATTERN)
   ) u_pattern (
      .addr(beat_addr),
      .data(pat_data)
   );

   assign last_beat  = (beat_cnt == LAST_BEAT);
   assign last_burst = (burst_cnt == LAST_BURST);

`ifdef RAM_INIT_VERIFY_EN
   logic rd_bad;
   assign rd_bad = (i_rdata != pat_data) || (i_rresp != AXI_RESP_OKAY) || (i_rlast != last_beat);
`endif

   always_comb begin
      nxt_state      = state;
      nxt_burst_addr = burst_addr;
      nxt_beat_addr  = beat_addr;
      nxt_burst_cnt  = burst_cnt;
      nxt_beat_cnt   = beat_cnt;
      nxt_done       = done_q;
      nxt_error      = error_q;
      case (state)
         ST_IDLE, ST_DONE: begin
            if (i_start) begin
               nxt_state      = ST_WR_AW;
               nxt_burst_addr = BASE_ADDR;
               nxt_beat_addr  = BASE_ADDR;
               nxt_burst_cnt  = '0;
               nxt_beat_cnt   = '0;
               nxt_done       = 1'b0;
               nxt_error      = 1'b0;
            end
         end
         ST_WR_AW: begin
            if (i_awready) begin
               nxt_state     = ST_WR_W;
               nxt_beat_addr = burst_addr;
               nxt_beat_cnt  = '0;
            end
         end
         ST_WR_W: begin
            if (i_wready) begin
               nxt_beat_addr = beat_addr + 32'd8;
               nxt_beat_cnt  = beat_cnt + 1'b1;
               if (last_beat) nxt_state = ST_WR_B;
            end
         end
         ST_WR_B: begin
            if (i_bvalid) begin
               if (i_bresp != AXI_RESP_OKAY) begin
                  nxt_state = ST_DONE;
                  nxt_done  = 1'b1;
                  nxt_error = 1'b1;
               end else if (!last_burst) begin
                  nxt_state      = ST_WR_AW;
                  nxt_burst_cnt  = burst_cnt + 1'b1;
                  nxt_burst_addr = burst_addr + BURST_BYTES;
               end else begin
`ifdef RAM_INIT_VERIFY_EN
                  nxt_state      = ST_RD_AR;
                  nxt_burst_cnt  = '0;
                  nxt_burst_addr = BASE_ADDR;
`else
                  nxt_state      = ST_DONE;
                  nxt_done       = 1'b1;
`endif
               end
            end
         end
`ifdef RAM_INIT_VERIFY_EN
         ST_RD_AR: begin
            if (i_arready) begin
               nxt_state     = ST_RD_R;
               nxt_beat_addr = burst_addr;
               nxt_beat_cnt  = '0;
            end
         end
         ST_RD_R: begin
            if (i_rvalid) begin
               nxt_beat_addr = beat_addr + 32'd8;
               nxt_beat_cnt  = beat_cnt + 1'b1;
               if (rd_bad) begin
                  nxt_state = ST_DONE;
                  nxt_done  = 1'b1;
                  nxt_error = 1'b1;
               end else if (last_beat) begin
                  if (!last_burst) begin
                     nxt_state      = ST_RD_AR;
                     nxt_burst_cnt  = burst_cnt + 1'b1;
                     nxt_burst_addr = burst_addr + BURST_BYTES;
                  end else begin
                     nxt_state = ST_DONE;
                     nxt_done  = 1'b1;
                  end
               end
            end
         end
`endif
         default: nxt_state = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= ST_IDLE;
         burst_addr <= BASE_ADDR;
         beat_addr  <= BASE_ADDR;
         burst_cnt  <= '0;
         beat_cnt   <= '0;
         done_q     <= 1'b0;
         error_q    <= 1'b0;
      end else begin
         state      <= nxt_state;
         burst_addr <= nxt_burst_addr;
         beat_addr  <= nxt_beat_addr;
         burst_cnt  <= nxt_burst_cnt;
         beat_cnt   <= nxt_beat_cnt;
         done_q     <= nxt_done;
         error_q    <= nxt_error;
      end
   end

   // Payload fields are gated by their phase so every output idles at zero.
   assign aw_phase     = (state == ST_WR_AW);
   assign w_phase      = (state == ST_WR_W);
   assign o_init_done  = done_q;
   assign o_init_error = error_q;
   assign o_awid       = '0;
   assign o_awaddr     = aw_phase ? burst_addr : 32'h0;
   assign o_awlen      = aw_phase ? AXI_LEN : 8'h0;
   assign o_awsize     = aw_phase ? AXI_SIZE_8B : 3'd0;
   assign o_awburst    = aw_phase ? AXI_BURST_INCR : 2'b00;
   assign o_awvalid    = aw_phase;
   assign o_wdata      = w_phase ? pat_data : 64'h0;
   assign o_wstrb      = w_phase ? 8'hFF : 8'h00;
   assign o_wlast      = w_phase && last_beat;
   assign o_wvalid     = w_phase;
   assign o_bready     = (state == ST_WR_B);
   assign o_arid       = '0;

`ifdef RAM_INIT_VERIFY_EN
   logic ar_phase;
   assign ar_phase  = (state == ST_RD_AR);
   assign o_araddr  = ar_phase ? burst_addr : 32'h0;
   assign o_arlen   = ar_phase ? AXI_LEN : 8'h0;
   assign o_arsize  = ar_phase ? AXI_SIZE_8B : 3'd0;
   assign o_arburst = ar_phase ? AXI_BURST_INCR : 2'b00;
   assign o_arvalid = ar_phase;
   assign o_rready  = (state == ST_RD_R);

   logic unused_ids;
   assign unused_ids = ^{i_bid, i_rid};
`else
   logic rready_q;
   // Read channel is left permanently drained once out of reset.
   always_ff @(posedge clk) begin
      if (rst) rready_q <= 1'b0;
      else     rready_q <= 1'b1;
   end

   assign o_araddr  = 32'h0;
   assign o_arlen   = 8'h0;
   assign o_arsize  = 3'd0;
   assign o_arburst = 2'b00;
   assign o_arvalid = 1'b0;
   assign o_rready  = rready_q;

   logic unused_rd;
   assign unused_rd = ^{i_bid, i_rid, i_arready, i_rdata, i_rresp, i_rlast, i_rvalid, pat_data[0]};
`endif

endmodule

// File: tb/tb_axi_ram_init_ctrl.sv
// Directed bench: reactive AXI slave with memory image, scoreboard queues of expected AW/W/AR traffic.
module tb_axi_ram_init_ctrl;

   localparam int unsigned MEM   = 32'h400;
   localparam int          BL    = 16;
   localparam int          NB    = MEM / (BL * 8);
   localparam int          WORDS = MEM / 8;
   localparam logic [63:0] PAT   = 64'hDEAD_BEEF_A5A5_0000;
`ifdef RAM_INIT_VERIFY_EN
   localparam logic RREADY_IDLE = 1'b0;
`else
   localparam logic RREADY_IDLE = 1'b1;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic start = 1'b0;
   logic init_done, init_error;
   logic [5:0]  awid, bid, arid, rid;
   logic [31:0] awaddr, araddr;
   logic [7:0]  awlen, arlen, wstrb;
   logic [2:0]  awsize, arsize;
   logic [1:0]  awburst, arburst, bresp, rresp;
   logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;
   logic        arvalid, arready, rlast, rvalid, rready;
   logic [63:0] wdata, rdata;

   always #5 clk = ~clk;

   axi_ram_init_ctrl #(
      .MEM_SIZE(MEM), .BASE_ADDR(32'h0), .BURST_LEN(BL), .ID_WIDTH(6), .FILL_PATTERN(PAT)
   ) dut (
      .clk(clk), .rst(rst), .i_start(start),
      .o_init_done(init_done), .o_init_error(init_error),
      .o_awid(awid), .o_awaddr(awaddr), .o_awlen(awlen), .o_awsize(awsize),
      .o_awburst(awburst), .o_awvalid(awvalid), .i_awready(awready),
      .o_wdata(wdata), .o_wstrb(wstrb), .o_wlast(wlast), .o_wvalid(wvalid), .i_wready(wready),
      .i_bid(bid), .i_bresp(bresp), .i_bvalid(bvalid), .o_bready(bready),
      .o_arid(arid), .o_araddr(araddr), .o_arlen(arlen), .o_arsize(arsize),
      .o_arburst(arburst), .o_arvalid(arvalid), .i_arready(arready),
      .i_rid(rid), .i_rdata(rdata), .i_rresp(rresp), .i_rlast(rlast), .i_rvalid(rvalid),
      .o_rready(rready)
   );

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic [63:0] mem [WORDS];
   logic [31:0] exp_aw_q [$];
   logic [64:0] exp_w_q  [$];
   logic [31:0] exp_ar_q [$];
   int aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt, last_hs_cyc;
   int err_burst = -1;
   bit stall_en = 1'b0;
   bit corrupt_en = 1'b0;
   int clr_seq = 0;
   int clr_seen = 0;
   int aw_st, w_st, ar_st, b_wait, r_wait, rd_beat;
   bit b_pend, r_act, prev_w_stall;
   logic [65:0] prev_w;
   logic [31:0] wr_ptr, rd_ptr;

   task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [255:0] outs();
      return 256'({awid, awaddr, awlen, awsize, awburst, awvalid, wdata, wstrb, wlast, wvalid,
                   bready, arid, araddr, arlen, arsize, arburst, arvalid, rready,
                   init_done, init_error});
   endfunction

   task automatic rnd_rdy(inout int st, output logic r);
      if (!stall_en || st >= 5 || $urandom_range(0, 2) == 0) begin
         r = 1'b1;
         st = 0;
      end else begin
         r = 1'b0;
         st++;
      end
   endtask

   // Slave: drive at negedge, then resolve the handshakes that the next posedge will take.
   always @(negedge clk) begin
      bid = '0;
      rid = '0;
      if (rst) begin
         awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = 2'b00;
         arready = 1'b0; rvalid = 1'b0; rdata = '0; rresp = 2'b00; rlast = 1'b0;
         b_pend = 1'b0; r_act = 1'b0; prev_w_stall = 1'b0;
         aw_st = 0; w_st = 0; ar_st = 0;
      end else begin
         if (clr_seen != clr_seq) begin
            clr_seen = clr_seq;
            aw_cnt = 0; w_cnt = 0; b_cnt = 0; ar_cnt = 0; r_cnt = 0;
            b_pend = 1'b0; r_act = 1'b0; prev_w_stall = 1'b0;
            for (int i = 0; i < WORDS; i++) mem[i] = 64'h0;
         end
         rnd_rdy(aw_st, awready);
         rnd_rdy(w_st, wready);
         bvalid = b_pend && (b_wait == 0);
         if (b_pend && b_wait > 0) b_wait--;
         bresp = (b_cnt == err_burst) ? 2'b10 : 2'b00;
`ifdef RAM_INIT_VERIFY_EN
         rnd_rdy(ar_st, arready);
         rvalid = r_act && (r_wait == 0);
         if (r_act && r_wait > 0) r_wait--;
         rdata = (rd_ptr < MEM) ? mem[rd_ptr / 8] : 64'h0;
         rlast = (rd_beat == BL - 1);
         rresp = 2'b00;
`else
         arready = 1'b0; rvalid = 1'b0; rdata = '0; rresp = 2'b00; rlast = 1'b0;
`endif
         #1;
         if (prev_w_stall) chk("w_hold_under_stall", {wvalid, wlast, wdata}, prev_w);
         prev_w_stall = wvalid && !wready;
         prev_w = {wvalid, wlast, wdata};
         if (awvalid && awready) begin
            chk("aw_expected", exp_aw_q.size() != 0, 1'b1);
            if (exp_aw_q.size() != 0) chk("aw_addr", awaddr, exp_aw_q.pop_front());
            chk("aw_fields", {awid, awlen, awsize, awburst}, {6'd0, 8'(BL - 1), 3'd3, 2'b01});
            wr_ptr = awaddr;
            aw_cnt++;
         end
         if (wvalid && wready) begin
            chk("w_expected", exp_w_q.size() != 0, 1'b1);
            if (exp_w_q.size() != 0) chk("w_beat", {wlast, wdata}, exp_w_q.pop_front());
            chk("w_strb", wstrb, 8'hFF);
            if (wr_ptr < MEM) mem[wr_ptr / 8] = wdata;
            wr_ptr += 8;
            w_cnt++;
            if (wlast) begin
               b_pend = 1'b1;
               b_wait = stall_en ? $urandom_range(0, 5) : 0;
            end
         end
         if (bvalid && bready) begin
            b_pend = 1'b0;
            b_cnt++;
            last_hs_cyc = cyc + 1;
            if (b_cnt == NB && corrupt_en) mem[32'h208 / 8] = mem[32'h208 / 8] ^ 64'h1;
         end
`ifdef RAM_INIT_VERIFY_EN
         if (arvalid && arready) begin
            chk("ar_expected", exp_ar_q.size() != 0, 1'b1);
            if (exp_ar_q.size() != 0) chk("ar_addr", araddr, exp_ar_q.pop_front());
            chk("ar_fields", {arid, arlen, arsize, arburst}, {6'd0, 8'(BL - 1), 3'd3, 2'b01});
            rd_ptr = araddr;
            rd_beat = 0;
            r_act = 1'b1;
            r_wait = stall_en ? $urandom_range(0, 3) : 0;
            ar_cnt++;
         end
         if (rvalid && rready) begin
            r_cnt++;
            last_hs_cyc = cyc + 1;
            rd_ptr += 8;
            if (rd_beat == BL - 1) r_act = 1'b0;
            else begin
               rd_beat++;
               r_wait = stall_en ? $urandom_range(0, 2) : 0;
            end
         end
`endif
      end
   end

   task automatic step();
      @(negedge clk);
      #3;
   endtask

   task automatic prep(input int err_b, input bit stall, input bit corrupt, input int n_bursts);
      exp_aw_q.delete();
      exp_w_q.delete();
      exp_ar_q.delete();
      err_burst = err_b;
      stall_en = stall;
      corrupt_en = corrupt;
      clr_seq++;
      for (int b = 0; b < n_bursts; b++) begin
         exp_aw_q.push_back(32'(b * BL * 8));
         for (int k = 0; k < BL; k++)
            exp_w_q.push_back({1'(k == BL - 1), PAT ^ {32'h0, 32'(b * BL * 8 + k * 8)}});
      end
      for (int b = 0; b < NB; b++) exp_ar_q.push_back(32'(b * BL * 8));
   endtask

   task automatic pulse_start(input string tag);
      start = 1'b1;
      step();
      start = 1'b0;
      chk({tag, "_awvalid_rise"}, awvalid, 1'b1);
      chk({tag, "_flags_clear"}, {init_done, init_error}, 2'b00);
   endtask

   task automatic wait_done(input string tag);
      int n = 0;
      while (init_done !== 1'b1 && n < 5000) begin
         step();
         n++;
      end
      chk({tag, "_done"}, init_done, 1'b1);
      chk({tag, "_done_timing"}, cyc, last_hs_cyc);
   endtask

   initial begin
      int bad;
      int n;
      step();
      step();
      chk("reset_outputs", outs(), '0);
      rst = 1'b0;
      step();
      chk("idle_rready", rready, RREADY_IDLE);
      chk("idle_flags", {init_done, init_error, awvalid}, 3'b000);

      prep(-1, 1'b0, 1'b0, NB);
      pulse_start("basic");
      wait_done("basic");
      chk("basic_error", init_error, 1'b0);
      chk("basic_aw_count", aw_cnt, NB);
      chk("basic_w_count", w_cnt, NB * BL);
      chk("basic_word_1f8", mem[32'h1F8 / 8], PAT ^ 64'h1F8);
      chk("basic_aw_left", exp_aw_q.size(), 0);
`ifdef RAM_INIT_VERIFY_EN
      chk("basic_r_count", r_cnt, NB * BL);
`endif

      prep(-1, 1'b1, 1'b0, NB);
      pulse_start("stall");
      wait_done("stall");
      chk("stall_error", init_error, 1'b0);
      bad = 0;
      for (int i = 0; i < WORDS; i++)
         if (mem[i] !== (PAT ^ {32'h0, 32'(i * 8)})) bad++;
      chk("stall_image", bad, 0);
      chk("stall_w_left", exp_w_q.size(), 0);

      prep(3, 1'b0, 1'b0, 4);
      pulse_start("werr");
      wait_done("werr");
      chk("werr_error", init_error, 1'b1);
      repeat (20) step();
      chk("werr_aw_count", aw_cnt, 4);
      chk("werr_w_left", exp_w_q.size(), 0);
      chk("werr_sticky", {init_done, init_error}, 2'b11);

`ifdef RAM_INIT_VERIFY_EN
      prep(-1, 1'b0, 1'b1, NB);
      pulse_start("verify");
      wait_done("verify");
      chk("verify_error", init_error, 1'b1);
      chk("verify_ar_count", ar_cnt, 5);
      chk("verify_ar_left", exp_ar_q.size(), NB - 5);
`endif

      prep(-1, 1'b0, 1'b0, NB);
      pulse_start("rst_run");
      n = 0;
      while (w_cnt < 2 * BL + 7 && n < 2000) begin
         step();
         n++;
      end
      chk("rst_reached_burst2", w_cnt >= 2 * BL + 7, 1'b1);
      rst = 1'b1;
      step();
      chk("rst_midburst_outputs", outs(), '0);
      rst = 1'b0;
      step();
      prep(-1, 1'b0, 1'b0, NB);
      pulse_start("restart");
      repeat (5) step();
      start = 1'b1;
      step();
      start = 1'b0;
      wait_done("restart");
      chk("restart_error", init_error, 1'b0);
      chk("restart_aw_count", aw_cnt, NB);
      chk("restart_w_count", w_cnt, NB * BL);
      chk("restart_aw_left", exp_aw_q.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #800000;
      $display("FAIL watchdog expired observed=running expected=finished");
      $fatal(1, "watchdog");
   end

endmodule
